// File: rtl/async_fifo_rd_pkg.sv
// Shared definitions for the async FIFO read-side drain stage.
// Optional statistics are enabled by defining ASYNC_FIFO_RD_STATS_EN.
package async_fifo_rd_pkg;

    localparam int DSIZE_DEF   = 8;
    localparam int PKT_LEN_DEF = 4;
    localparam int CNT_W_DEF   = 16;

    // Skid buffer occupancy: 0, 1 or 2 entries
    typedef logic [1:0] occ_t;

    // Width of the beat counter; at least one bit even for single-beat packets
    function automatic int beat_w(input int pkt_len);
        return (pkt_len <= 2) ? 1 : $clog2(pkt_len);
    endfunction

endpackage

// File: rtl/async_fifo_rd_skid.sv
// Two-entry skid buffer: head entry drives the output, tail catches the one
// extra word taken while the consumer is stalled. Flush drops both entries.
module async_fifo_rd_skid
    import async_fifo_rd_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output occ_t             occ,
    output logic [DSIZE-1:0] head
);

    occ_t             occ_q, occ_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] tail_q, tail_d;
    logic             do_push;
    logic             do_pop;

    // Guard against pushing into a full buffer or popping an empty one
    assign do_push = push && (occ_q != 2'd2);
    assign do_pop  = pop && (occ_q != 2'd0);

    // Next-state: flush wins, otherwise push/pop update keeping FIFO order
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_d = push_data;
                    else               tail_d = push_data;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_d = push_data;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer registers; reset also clears the stored data
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ  = occ_q;
    assign head = head_q;

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side drain stage for an async FIFO: pops words into a 2-entry skid
// buffer, presents them as a valid/ready stream framed into PKT_LEN-beat
// packets, with synchronous flush. rinc depends only on registered occupancy,
// so there is no combinational path from m_ready to rinc.
// Define ASYNC_FIFO_RD_STATS_EN to add the word/stall statistics counters.
module async_fifo_rd_stream
    import async_fifo_rd_pkg::*;
#(
    parameter int DSIZE   = DSIZE_DEF,
    parameter int PKT_LEN = PKT_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             flush,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready
`ifdef ASYNC_FIFO_RD_STATS_EN
    ,
    output logic [CNT_W-1:0] rd_word_cnt,
    output logic [CNT_W-1:0] rd_stall_cnt
`endif
);

    localparam int             BW        = beat_w(PKT_LEN);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(PKT_LEN - 1);

    if (PKT_LEN < 1 || CNT_W < 1) begin : g_bad_param
        $error("async_fifo_rd_stream: PKT_LEN and CNT_W must be >= 1");
    end

    occ_t          occ;
    logic          pop;
    logic [BW-1:0] beat_q, beat_d;

    // Pop from the FIFO whenever a word exists and the buffer has room;
    // held off during reset and flush so no FIFO word is lost
    assign rinc    = !rrst && !rempty && !flush && (occ != 2'd2);
    assign m_valid = !rrst && !flush && (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_last  = m_valid && (beat_q == LAST_BEAT);

    async_fifo_rd_skid #(
        .DSIZE (DSIZE)
    ) u_skid (
        .clk       (rclk),
        .rst       (rrst),
        .flush     (flush),
        .push      (rinc),
        .push_data (rdata),
        .pop       (pop),
        .occ       (occ),
        .head      (m_data)
    );

    // Beat position within the packet; held across empty gaps, cleared by flush
    always_comb begin
        beat_d = beat_q;
        if (flush) begin
            beat_d = '0;
        end else if (pop) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        end
    end

    // Beat counter register
    always_ff @(posedge rclk) begin
        if (rrst) beat_q <= '0;
        else      beat_q <= beat_d;
    end

`ifdef ASYNC_FIFO_RD_STATS_EN
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters; flush leaves them alone
    always_comb begin
        word_cnt_d  = word_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (rinc && (word_cnt_q != '1))
            word_cnt_d = word_cnt_q + CNT_W'(1);
        if (m_valid && !m_ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Statistics registers, cleared only by reset
    always_ff @(posedge rclk) begin
        if (rrst) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rd_word_cnt  = word_cnt_q;
    assign rd_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Bench for async_fifo_rd_stream: a queue stands in for the async FIFO, a
// queue-based model tracks buffered words and packet beat, and every cycle
// the outputs are compared. Directed sequences pin the model with literals.
module tb_async_fifo_rd_stream;

    localparam int DSIZE   = 8;
    localparam int PKT_LEN = 4;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rrst;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic             flush;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
`ifdef ASYNC_FIFO_RD_STATS_EN
    logic [CNT_W-1:0] rd_word_cnt;
    logic [CNT_W-1:0] rd_stall_cnt;
`endif

    async_fifo_rd_stream #(
        .DSIZE   (DSIZE),
        .PKT_LEN (PKT_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .rclk    (clk),
        .rrst    (rrst),
        .rdata   (rdata),
        .rempty  (rempty),
        .rinc    (rinc),
        .flush   (flush),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready)
`ifdef ASYNC_FIFO_RD_STATS_EN
        ,
        .rd_word_cnt  (rd_word_cnt),
        .rd_stall_cnt (rd_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DSIZE-1:0] src[$];    // words sitting in the upstream FIFO
    logic [DSIZE-1:0] mbuf[$];   // words taken but not yet delivered
    int               mbeat = 0;
    int               mwc   = 0;
    int               msc   = 0;
    bit               rst_prev = 1'b0;
    bit               pop_src  = 1'b0;
    logic [DSIZE-1:0] log_d[$];
    bit               log_l[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_src();
        rempty = (src.size() == 0);
        rdata  = (src.size() != 0) ? src[0] : DSIZE'($urandom);
    endtask

    // Call only right after cyc(), so FIFO changes land before the next check
    task automatic push_w(input logic [DSIZE-1:0] w);
        src.push_back(w);
        drive_src();
    endtask

    task automatic cyc(input bit f, input bit r, input bit rs);
        @(posedge clk);
        #1;
        if (pop_src) begin
            void'(src.pop_front());
            pop_src = 1'b0;
        end
        flush   = f;
        m_ready = r;
        rrst    = rs;
        drive_src();
    endtask

    task automatic clear_log();
        log_d.delete();
        log_l.delete();
    endtask

    // Per-cycle compare against the model, then advance the model
    initial begin
        @(posedge clk);
        forever begin
            bit er, ev;
            @(negedge clk);
            er = !rrst && !flush && (src.size() != 0) && (mbuf.size() < 2);
            ev = !rrst && !flush && (mbuf.size() != 0);
            chk("rinc", rinc, er);
            chk("m_valid", m_valid, ev);
            if (ev) begin
                chk("m_data", m_data, mbuf[0]);
                chk("m_last", m_last, (mbeat == PKT_LEN - 1));
            end else begin
                chk("m_last_idle", m_last, 0);
            end
            if (rrst && rst_prev) chk("m_data_rst", m_data, 0);
`ifdef ASYNC_FIFO_RD_STATS_EN
            chk("rd_word_cnt", rd_word_cnt, mwc);
            chk("rd_stall_cnt", rd_stall_cnt, msc);
`endif
            if (m_valid === 1'b1 && m_ready) begin
                log_d.push_back(m_data);
                log_l.push_back(m_last);
            end
            if (rrst) begin
                mbuf.delete();
                mbeat = 0;
                mwc   = 0;
                msc   = 0;
            end else if (flush) begin
                mbuf.delete();
                mbeat = 0;
            end else begin
                if (ev && m_ready) begin
                    void'(mbuf.pop_front());
                    mbeat = (mbeat + 1) % PKT_LEN;
                end
                if (er) begin
                    mbuf.push_back(src[0]);
                    pop_src = 1'b1;
                end
                if (er && mwc < CMAX) mwc++;
                if (ev && !m_ready && msc < CMAX) msc++;
            end
            rst_prev = rrst;
        end
    end

    // Stimulus
    initial begin
        rrst    = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) src.push_back(DSIZE'(8'h10 + i));
        drive_src();

        // Reset held for three edges with the FIFO non-empty
        cyc(0, 1, 1);
        @(negedge clk);
        chk("rst_rinc", rinc, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
`ifdef ASYNC_FIFO_RD_STATS_EN
        chk("rst_wcnt", rd_word_cnt, 0);
        chk("rst_scnt", rd_stall_cnt, 0);
`endif
        cyc(0, 1, 1);
        cyc(0, 1, 0);
        clear_log();
        @(negedge clk);
        chk("lat_rinc", rinc, 1);
        chk("lat_valid0", m_valid, 0);
        cyc(0, 1, 0);
        @(negedge clk);
        chk("lat_valid1", m_valid, 1);
        chk("lat_data", m_data, 8'h10);

        // Streaming 0x10..0x17 back to back
        repeat (9) cyc(0, 1, 0);
        chk("stream_cnt", log_d.size(), 8);
        for (int i = 0; i < 8 && i < log_d.size(); i++) begin
            chk("stream_data", log_d[i], 8'h10 + i);
            chk("stream_last", log_l[i], (i == 3 || i == 7));
        end

        // Backpressure for 5 cycles mid-stream
        cyc(0, 1, 0);
        clear_log();
        for (int i = 0; i < 12; i++) push_w(DSIZE'(8'h20 + i));
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        repeat (5) cyc(0, 0, 0);
        @(negedge clk);
        chk("bp_rinc", rinc, 0);
        chk("bp_valid", m_valid, 1);
        repeat (14) cyc(0, 1, 0);
`ifdef ASYNC_FIFO_RD_STATS_EN
        chk("bp_stall_cnt", rd_stall_cnt, 5);
`endif
        chk("bp_cnt", log_d.size(), 12);
        for (int i = 0; i < 12 && i < log_d.size(); i++) begin
            chk("bp_data", log_d[i], 8'h20 + i);
            chk("bp_last", log_l[i], (i % 4 == 3));
        end

        // FIFO runs empty mid-packet
        cyc(0, 1, 0);
        clear_log();
        push_w(8'hA0);
        push_w(8'hA1);
        repeat (6) cyc(0, 1, 0);
        push_w(8'hA2);
        push_w(8'hA3);
        repeat (5) cyc(0, 1, 0);
        chk("gap_cnt", log_d.size(), 4);
        for (int i = 0; i < 4 && i < log_d.size(); i++) begin
            chk("gap_data", log_d[i], 8'hA0 + i);
            chk("gap_last", log_l[i], (i == 3));
        end

        // Flush with two words buffered at beat 2
        cyc(0, 1, 0);
        clear_log();
        push_w(8'h50);
        push_w(8'h51);
        repeat (4) cyc(0, 1, 0);
        push_w(8'h55);
        push_w(8'h66);
        repeat (2) cyc(0, 0, 0);
        cyc(1, 0, 0);
        @(negedge clk);
        chk("fl_valid", m_valid, 0);
        chk("fl_rinc", rinc, 0);
        cyc(0, 1, 0);
        push_w(8'h77);
        push_w(8'h78);
        push_w(8'h79);
        push_w(8'h7A);
        repeat (8) cyc(0, 1, 0);
        begin
            logic [DSIZE-1:0] fexp[6];
            fexp = '{8'h50, 8'h51, 8'h77, 8'h78, 8'h79, 8'h7A};
            chk("fl_cnt", log_d.size(), 6);
            for (int i = 0; i < 6 && i < log_d.size(); i++) begin
                chk("fl_data", log_d[i], fexp[i]);
                chk("fl_last", log_l[i], (i == 5));
            end
        end

        // Randomised traffic with stalls, gaps, flushes and resets
        for (int n = 0; n < 3000; n++) begin
            bit f, r, rs;
            f  = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 299) == 0);
            r  = ($urandom_range(0, 3) != 0);
            cyc(f, r, rs);
            if ($urandom_range(0, 2) != 0 && src.size() < 6 && (n % 200) < 170)
                push_w(DSIZE'($urandom));
        end

`ifdef ASYNC_FIFO_RD_STATS_EN
        // Word counter saturation
        cyc(0, 1, 1);
        src.delete();
        drive_src();
        cyc(0, 1, 1);
        cyc(0, 1, 0);
        for (int i = 0; i < 20; i++) push_w(DSIZE'(i));
        repeat (25) cyc(0, 1, 0);
        @(negedge clk);
        chk("sat_wcnt", rd_word_cnt, 15);
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/async_fifo_rd_stream.md
# async_fifo_rd_stream

Read-side drain stage sitting directly downstream of the asynchronous FIFO's read port, entirely in the read clock domain. It pulls words from the FIFO whenever it is non-empty and buffer space exists, and presents them as a valid/ready stream. It frames that stream into fixed-length packets with a last-beat marker and supports a synchronous flush. No combinational path runs from `m_ready` to `rinc`.

## Interface
Parameters:
- `DSIZE`, 8: FIFO data width.
- `PKT_LEN`, 4: beats per packet; legal range ≥1.
- `CNT_W`, 16: statistics counter width (used only with stats enabled).

Ports:
- `rclk` in 1: read-domain clock; single clock for the whole block.
- `rrst` in 1: reset, synchronous, active-high.
- `rdata` in DSIZE: FIFO read data; the word at the current read pointer, valid whenever `rempty`=0.
- `rempty` in 1: FIFO empty flag, already synchronised to `rclk`.
- `rinc` out 1: FIFO read increment; pops one word per cycle high.
- `flush` in 1: synchronous discard of buffered data and packet state.
- `m_data` out DSIZE: stream data.
- `m_valid` out 1: stream valid.
- `m_last` out 1: final beat of the packet.
- `m_ready` in 1: stream ready from the consumer.
- `rd_word_cnt` out CNT_W: words popped (stats build only).
- `rd_stall_cnt` out CNT_W: backpressure cycles (stats build only).

## Operation
- 2-entry skid buffer, occupancy `occ` ∈ {0,1,2}. Head entry drives `m_data`.
- `rinc = !rempty && !flush && (occ < 2)`. `rinc` depends on registered `occ` only, never on `m_ready`.
- Push: `rinc`=1 writes `rdata` at the tail.
- Pop: `m_valid && m_ready` removes the head.
- Push and pop in the same cycle: `occ` unchanged; order preserved.
- `m_valid = (occ != 0) && !flush`.
- Beat counter `beat` is 0..PKT_LEN-1 and advances on each pop. It wraps to 0 after PKT_LEN-1.
- `m_last = m_valid && (beat == PKT_LEN-1)`. With PKT_LEN=1, `m_last` equals `m_valid`.
- Flush cycle, which has priority over everything:
  - `occ`←0 and `beat`←0.
  - `rinc` is forced 0, so no FIFO word is lost.
  - `m_valid` is forced 0, so no transfer occurs.
  - Buffered words are dropped.
- Reset behaves as flush and also clears `m_data` to 0 and the stats counters.
- Undefined input `rdata` while `rempty`=1 is never captured.

## Timing
- Reset values: `rinc`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `rd_word_cnt`=0, `rd_stall_cnt`=0. `rinc` rises no earlier than the first cycle after `rrst` deasserts, and only if `rempty`=0.
- Latency: word visible with `rempty`=0 in cycle t gives `rinc`=1 in t and `m_valid`=1 in t+1.
- Throughput: one word per cycle sustained when `m_ready`=1 and the FIFO is non-empty (`occ` holds at 1).
- `m_ready` low:
  - One more word is taken (`occ`→2), then `rinc`=0.
  - `m_data`/`m_valid`/`m_last` hold stable until the handshake.
- FIFO goes empty mid-packet: `m_valid` drops after the buffer drains. `beat` is retained, and the packet resumes where it left off.
- Reset or flush mid-packet: the next accepted beat is beat 0.

## Configuration
- `ASYNC_FIFO_RD_STATS_EN` defined:
  - `rd_word_cnt` increments on every `rinc`.
  - `rd_stall_cnt` increments on every cycle with `m_valid && !m_ready`.
  - Both saturate at all-ones and are cleared only by `rrst`; flush does not clear them.
- Undefined: both ports and all counter logic are absent.

## Structure
- Shared package `async_fifo_rd_pkg`:
  - default `DSIZE`/`PKT_LEN`/`CNT_W` constants;
  - `occ_t` 2-bit occupancy typedef;
  - beat width function, `$clog2(PKT_LEN)` with minimum 1.
- Sub-module `async_fifo_rd_skid` holds the 2-entry buffer with push/pop/flush and `occ`. The top level holds the `rinc` logic, packet framing and stats.

## Test plan
- Reset: `rrst`=1 for 3 cycles with `rempty`=0 → all outputs 0. `rinc` first rises the cycle after release; `m_valid` rises the cycle after that.
- Streaming: FIFO holds 0x10..0x17, `m_ready`=1, PKT_LEN=4 → 8 beats on consecutive cycles, in order, with `m_last` on 0x13 and 0x17.
- Backpressure: `m_ready`=0 for 5 cycles mid-stream → exactly 2 words buffered, `rinc`=0 thereafter, `m_data` stable. On release there are no drops or duplicates. `rd_stall_cnt` = 5 (stats build).
- Empty mid-packet: FIFO holds 0xA0, 0xA1, then empty for 4 cycles, then 0xA2, 0xA3 → `m_last` only on 0xA3.
- Flush: `occ`=2 (0x55, 0x66 buffered) and beat=2, then `flush` for 1 cycle → `m_valid`=0 and `rinc`=0 that cycle. The next word, 0x77, emerges as beat 0, and 0x55/0x66 never appear.
- Saturation (stats, CNT_W=4): 20 pops → `rd_word_cnt`=15.
